// File: rtl/slug_boot_ctrl.sv
// slug_boot_ctrl: boot/run controller for the slug 4-bit CPU.
// Streams a program image into program memory, keeps the core in reset while
// loading and for a short window afterwards, then gates the core clock-enable
// for run / halt / single-step with one program-counter breakpoint.
module slug_boot_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int RST_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_load,
   input  logic              cmd_run,
   input  logic              cmd_step,
   input  logic              cmd_halt,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              brk_en,
   input  logic [ADDR_W-1:0] brk_addr,
   input  logic [ADDR_W-1:0] pc,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [7:0]        pm_wdata,
   output logic              cpu_rst,
   output logic              cpu_en,
   output logic [2:0]        state,
   output logic              brk_hit,
   output logic              ld_err
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HOLD = 3'd2,
      ST_HALT = 3'd3,
      ST_RUN  = 3'd4,
      ST_STEP = 3'd5
   } state_t;

   // Hold counter runs 0 .. RST_HOLD-1 while in HOLD.
   localparam int                HCNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(RST_HOLD - 1);
   localparam logic [ADDR_W-1:0] ADDR_TOP  = {ADDR_W{1'b1}};

   state_t              state_r;
   state_t              state_nx_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [HCNT_W-1:0]   hold_cnt_r;
   logic                skip_r;
   logic                brk_hit_r;
   logic                ld_err_r;
   logic                pm_we_r;
   logic [ADDR_W-1:0]   pm_addr_r;
   logic [7:0]          pm_wdata_r;
   logic                cpu_rst_r;
   logic                ld_ready_r;

   logic                accept_s;
   logic                at_top_s;
   logic                brk_match_s;
   logic                load_go_s;
   logic                brk_fire_s;
   logic                cpu_en_s;
   logic                clr_brk_s;

   // Handshake and breakpoint qualifiers shared by the FSM and the datapath.
   always_comb begin
      accept_s    = ld_valid & ld_ready_r;
      at_top_s    = (addr_r == ADDR_TOP);
      brk_match_s = brk_en & (pc == brk_addr) & ~skip_r;
   end

   // Next-state and clock-enable decode; commands resolve as load > halt > step > run.
   always_comb begin
      state_nx_s = state_r;
      load_go_s  = 1'b0;
      brk_fire_s = 1'b0;
      cpu_en_s   = 1'b0;
      clr_brk_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_load) begin
               state_nx_s = ST_LOAD;
               load_go_s  = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s && (ld_last || at_top_s)) begin
               state_nx_s = ST_HOLD;
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_HOLD: begin
            // Core reset is synchronous, so it must be clocked during the hold window.
            cpu_en_s = 1'b1;
            if (hold_cnt_r == HOLD_LAST) begin
               state_nx_s = ST_HALT;
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         ST_HALT: begin
            if (cmd_load) begin
               state_nx_s = ST_LOAD;
               load_go_s  = 1'b1;
            end else if (cmd_halt) begin
               state_nx_s = ST_HALT;
            end else if (cmd_step) begin
               state_nx_s = ST_STEP;
               clr_brk_s  = 1'b1;
            end else if (cmd_run) begin
               state_nx_s = ST_RUN;
               clr_brk_s  = 1'b1;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         ST_RUN: begin
            if (cmd_load) begin
               state_nx_s = ST_LOAD;
               load_go_s  = 1'b1;
            end else if (cmd_halt) begin
               state_nx_s = ST_HALT;
               brk_fire_s = brk_match_s;
            end else if (brk_match_s) begin
               // Suppress the enable so the instruction at brk_addr does not execute.
               state_nx_s = ST_HALT;
               brk_fire_s = 1'b1;
            end else begin
               state_nx_s = ST_RUN;
               cpu_en_s   = 1'b1;
            end
         end
         ST_STEP: begin
            cpu_en_s   = 1'b1;
            state_nx_s = ST_HALT;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register plus state-derived registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cpu_rst_r  <= 1'b1;
         ld_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         cpu_rst_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_LOAD) ||
                       (state_nx_s == ST_HOLD);
         ld_ready_r <= (state_nx_s == ST_LOAD);
      end
   end

   // Load address pointer and one-cycle-latency program memory write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r     <= '0;
         pm_we_r    <= 1'b0;
         pm_addr_r  <= '0;
         pm_wdata_r <= 8'h00;
      end else begin
         pm_we_r <= accept_s;
         if (accept_s) begin
            pm_addr_r  <= addr_r;
            pm_wdata_r <= ld_data;
         end
         if (load_go_s) begin
            addr_r <= '0;
         end else if (accept_s && !at_top_s) begin
            // The pointer saturates at the top address instead of wrapping.
            addr_r <= addr_r + ADDR_W'(1);
         end
      end
   end

   // Reset-hold window counter and first-RUN-cycle breakpoint skip flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_r <= '0;
         skip_r     <= 1'b0;
      end else begin
         if ((state_r == ST_HOLD) && (state_nx_s == ST_HOLD)) begin
            hold_cnt_r <= hold_cnt_r + HCNT_W'(1);
         end else begin
            hold_cnt_r <= '0;
         end
         skip_r <= (state_nx_s == ST_RUN) && (state_r != ST_RUN);
      end
   end

   // Sticky status flags: breakpoint hit and load overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         brk_hit_r <= 1'b0;
         ld_err_r  <= 1'b0;
      end else begin
         if (load_go_s || clr_brk_s) begin
            brk_hit_r <= 1'b0;
         end else if (brk_fire_s) begin
            brk_hit_r <= 1'b1;
         end
         if (load_go_s) begin
            ld_err_r <= 1'b0;
         end else if (accept_s && at_top_s && !ld_last) begin
            ld_err_r <= 1'b1;
         end
      end
   end

   assign state    = state_r;
   assign cpu_rst  = cpu_rst_r;
   assign cpu_en   = cpu_en_s;
   assign ld_ready = ld_ready_r;
   assign pm_we    = pm_we_r;
   assign pm_addr  = pm_addr_r;
   assign pm_wdata = pm_wdata_r;
   assign brk_hit  = brk_hit_r;
   assign ld_err   = ld_err_r;

endmodule

// File: tb/tb_slug_boot_ctrl.sv
// Directed testbench for slug_boot_ctrl: one wide-address instance and one
// ADDR_W=4 instance for the address overrun case.
module tb_slug_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_load = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
   logic        ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0]  ld_data = 8'h00;
   logic        ld_ready;
   logic        brk_en = 1'b0;
   logic [15:0] brk_addr = 16'h0000, pc = 16'h0000;
   logic        pm_we, cpu_rst, cpu_en, brk_hit, ld_err;
   logic [15:0] pm_addr;
   logic [7:0]  pm_wdata;
   logic [2:0]  state;

   logic        b_cmd_load = 1'b0, b_ld_valid = 1'b0, b_ld_last = 1'b0;
   logic        b_zero = 1'b0;
   logic [7:0]  b_ld_data = 8'h00;
   logic [3:0]  b_brk_addr = 4'h0, b_pc = 4'h0;
   logic        b_ld_ready, b_pm_we, b_cpu_rst, b_cpu_en, b_brk_hit, b_ld_err;
   logic [3:0]  b_pm_addr;
   logic [7:0]  b_pm_wdata;
   logic [2:0]  b_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   slug_boot_ctrl #(.ADDR_W(16), .RST_HOLD(4)) dut (
      .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_step(cmd_step),
      .cmd_halt(cmd_halt), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .brk_en(brk_en), .brk_addr(brk_addr), .pc(pc), .pm_we(pm_we),
      .pm_addr(pm_addr), .pm_wdata(pm_wdata), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
      .state(state), .brk_hit(brk_hit), .ld_err(ld_err)
   );

   slug_boot_ctrl #(.ADDR_W(4), .RST_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .cmd_load(b_cmd_load), .cmd_run(b_zero), .cmd_step(b_zero),
      .cmd_halt(b_zero), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
      .ld_ready(b_ld_ready), .brk_en(b_zero), .brk_addr(b_brk_addr), .pc(b_pc), .pm_we(b_pm_we),
      .pm_addr(b_pm_addr), .pm_wdata(b_pm_wdata), .cpu_rst(b_cpu_rst), .cpu_en(b_cpu_en),
      .state(b_state), .brk_hit(b_brk_hit), .ld_err(b_ld_err)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({state, cpu_rst, cpu_en, ld_ready, pm_we, brk_hit, ld_err} !== {3'd0, 1'b1, 5'b00000}) begin
         errors++;
         $display("FAIL reset_ctrl got st=%0d rst=%b en=%b rdy=%b we=%b bh=%b le=%b want 0 1 0 0 0 0 0",
                  state, cpu_rst, cpu_en, ld_ready, pm_we, brk_hit, ld_err);
      end
      checks++;
      if ({pm_addr, pm_wdata} !== 24'h000000) begin
         errors++;
         $display("FAIL reset_pm got addr=%h data=%h want 0000 00", pm_addr, pm_wdata);
      end
      rst = 1'b0;
      cmd_run = 1'b1;
      cmd_step = 1'b1;
      @(negedge clk);
      cmd_run = 1'b0;
      cmd_step = 1'b0;
      #1;
      checks++;
      if ({state, cpu_rst, cpu_en} !== {3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL idle_ignores_run got st=%0d rst=%b en=%b want 0 1 0", state, cpu_rst, cpu_en);
      end
   endtask

   task automatic test_load_b2b();
      cmd_load = 1'b1;
      @(negedge clk);
      cmd_load = 1'b0;
      #1;
      checks++;
      if ({state, ld_ready, cpu_rst, cpu_en} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL load_entry got st=%0d rdy=%b rst=%b en=%b want 1 1 1 0", state, ld_ready, cpu_rst, cpu_en);
      end
      ld_valid = 1'b1;
      ld_data  = 8'hA5;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0000, 8'hA5}) begin
         errors++;
         $display("FAIL b2b_w0 got we=%b addr=%h data=%h want 1 0000 a5", pm_we, pm_addr, pm_wdata);
      end
      ld_data = 8'h3C;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0001, 8'h3C}) begin
         errors++;
         $display("FAIL b2b_w1 got we=%b addr=%h data=%h want 1 0001 3c", pm_we, pm_addr, pm_wdata);
      end
      ld_data = 8'hFF;
      ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      #1;
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0002, 8'hFF}) begin
         errors++;
         $display("FAIL b2b_w2 got we=%b addr=%h data=%h want 1 0002 ff", pm_we, pm_addr, pm_wdata);
      end
      checks++;
      if ({state, ld_ready, cpu_rst, cpu_en} !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL hold_entry got st=%0d rdy=%b rst=%b en=%b want 2 0 1 1", state, ld_ready, cpu_rst, cpu_en);
      end
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({state, cpu_rst, cpu_en, pm_we} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_cycle%0d got st=%0d rst=%b en=%b we=%b want 2 1 1 0", i, state, cpu_rst, cpu_en, pm_we);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({state, cpu_rst, cpu_en} !== {3'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL halt_after_hold got st=%0d rst=%b en=%b want 3 0 0", state, cpu_rst, cpu_en);
      end
   endtask

   task automatic test_load_stall();
      int writes;
      cmd_load = 1'b1;
      @(negedge clk);
      cmd_load = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 8'h11;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0000, 8'h11}) begin
         errors++;
         $display("FAIL stall_w0 got we=%b addr=%h data=%h want 1 0000 11", pm_we, pm_addr, pm_wdata);
      end
      ld_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (pm_we !== 1'b0) begin
         errors++;
         $display("FAIL stall_gap got we=%b want 0", pm_we);
      end
      ld_valid = 1'b1;
      ld_data  = 8'h22;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0001, 8'h22}) begin
         errors++;
         $display("FAIL stall_w1 got we=%b addr=%h data=%h want 1 0001 22", pm_we, pm_addr, pm_wdata);
      end
      ld_data = 8'h33;
      ld_last = 1'b1;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata, state} !== {1'b1, 16'h0002, 8'h33, 3'd2}) begin
         errors++;
         $display("FAIL stall_w2 got we=%b addr=%h data=%h st=%0d want 1 0002 33 2", pm_we, pm_addr, pm_wdata, state);
      end
      ld_data = 8'h44;
      ld_last = 1'b0;
      writes  = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (pm_we === 1'b1) writes++;
         if (ld_ready !== 1'b0) writes += 100;
      end
      checks++;
      if (writes !== 0) begin
         errors++;
         $display("FAIL hold_no_accept got extra=%0d want 0", writes);
      end
      checks++;
      if (state !== 3'd3) begin
         errors++;
         $display("FAIL stall_halt got st=%0d want 3", state);
      end
      ld_valid = 1'b0;
   endtask

   task automatic test_step();
      int pulses = 0;
      for (int k = 0; k < 3; k++) begin
         cmd_step = 1'b1;
         #1;
         if (cpu_en === 1'b1) pulses++;
         @(negedge clk);
         cmd_step = 1'b0;
         #1;
         if (cpu_en === 1'b1) pulses++;
         checks++;
         if (state !== 3'd5) begin
            errors++;
            $display("FAIL step%0d_state got %0d want 5", k, state);
         end
         @(negedge clk);
         #1;
         if (cpu_en === 1'b1) pulses++;
         checks++;
         if (state !== 3'd3) begin
            errors++;
            $display("FAIL step%0d_return got %0d want 3", k, state);
         end
      end
      checks++;
      if (pulses !== 3) begin
         errors++;
         $display("FAIL step_pulses got %0d want 3", pulses);
      end
   endtask

   task automatic test_breakpoint();
      brk_en   = 1'b1;
      brk_addr = 16'h0010;
      pc       = 16'h000E;
      cmd_run  = 1'b1;
      @(negedge clk);
      cmd_run = 1'b0;
      #1;
      checks++;
      if ({state, cpu_en} !== {3'd4, 1'b1}) begin
         errors++;
         $display("FAIL run_e got st=%0d en=%b want 4 1", state, cpu_en);
      end
      @(negedge clk);
      pc = 16'h000F;
      #1;
      checks++;
      if (cpu_en !== 1'b1) begin
         errors++;
         $display("FAIL run_f got en=%b want 1", cpu_en);
      end
      @(negedge clk);
      pc = 16'h0010;
      #1;
      checks++;
      if ({state, cpu_en} !== {3'd4, 1'b0}) begin
         errors++;
         $display("FAIL brk_gate got st=%0d en=%b want 4 0", state, cpu_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({state, brk_hit, cpu_en} !== {3'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL brk_halt got st=%0d hit=%b en=%b want 3 1 0", state, brk_hit, cpu_en);
      end
      cmd_run = 1'b1;
      @(negedge clk);
      cmd_run = 1'b0;
      #1;
      checks++;
      if ({state, brk_hit, cpu_en} !== {3'd4, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL resume_at_brk got st=%0d hit=%b en=%b want 4 0 1", state, brk_hit, cpu_en);
      end
      @(negedge clk);
      pc = 16'h0011;
      #1;
      checks++;
      if ({state, brk_hit, cpu_en} !== {3'd4, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL no_rehit got st=%0d hit=%b en=%b want 4 0 1", state, brk_hit, cpu_en);
      end
      cmd_halt = 1'b1;
      #1;
      checks++;
      if (cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL halt_gate got en=%b want 0", cpu_en);
      end
      @(negedge clk);
      cmd_halt = 1'b0;
      pc       = 16'h0010;
      cmd_step = 1'b1;
      @(negedge clk);
      cmd_step = 1'b0;
      #1;
      checks++;
      if ({state, cpu_en} !== {3'd5, 1'b1}) begin
         errors++;
         $display("FAIL step_ignores_brk got st=%0d en=%b want 5 1", state, cpu_en);
      end
      @(negedge clk);
      checks++;
      if ({state, brk_hit} !== {3'd3, 1'b0}) begin
         errors++;
         $display("FAIL step_no_hit got st=%0d hit=%b want 3 0", state, brk_hit);
      end
      brk_en = 1'b0;
   endtask

   task automatic test_load_halt_rst();
      pc      = 16'h0020;
      cmd_run = 1'b1;
      @(negedge clk);
      cmd_run  = 1'b0;
      cmd_load = 1'b1;
      cmd_halt = 1'b1;
      #1;
      checks++;
      if ({state, cpu_en} !== {3'd4, 1'b0}) begin
         errors++;
         $display("FAIL load_halt_gate got st=%0d en=%b want 4 0", state, cpu_en);
      end
      @(negedge clk);
      cmd_load = 1'b0;
      cmd_halt = 1'b0;
      checks++;
      if ({state, cpu_rst, ld_ready} !== {3'd1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL load_wins got st=%0d rst=%b rdy=%b want 1 1 1", state, cpu_rst, ld_ready);
      end
      ld_valid = 1'b1;
      ld_data  = 8'h5A;
      @(negedge clk);
      ld_data = 8'h6B;
      @(negedge clk);
      checks++;
      if ({pm_we, pm_addr, pm_wdata} !== {1'b1, 16'h0001, 8'h6B}) begin
         errors++;
         $display("FAIL preload_w1 got we=%b addr=%h data=%h want 1 0001 6b", pm_we, pm_addr, pm_wdata);
      end
      ld_data = 8'h7C;
      rst     = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      ld_valid = 1'b0;
      #1;
      checks++;
      if ({state, pm_we, pm_addr, ld_ready, cpu_rst} !== {3'd0, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rst_mid_load got st=%0d we=%b addr=%h rdy=%b rst=%b want 0 0 0000 0 1",
                  state, pm_we, pm_addr, ld_ready, cpu_rst);
      end
   endtask

   task automatic test_addr_overflow();
      int wc       = 0;
      int k        = 1;
      int bad      = 0;
      bit saw_hold = 1'b0;
      b_cmd_load = 1'b1;
      @(negedge clk);
      b_cmd_load = 1'b0;
      b_ld_valid = 1'b1;
      b_ld_data  = 8'h80;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (b_pm_we === 1'b1) begin
            if (b_pm_addr !== 4'(wc) || b_pm_wdata !== 8'(8'h80 + wc)) bad++;
            if (wc == 14 && b_ld_err !== 1'b0) bad += 100;
            wc++;
         end
         if (b_state === 3'd2) saw_hold = 1'b1;
         b_ld_data = 8'(8'h80 + k);
         k++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL ovf_contents got bad=%0d want 0", bad);
      end
      checks++;
      if (wc !== 16) begin
         errors++;
         $display("FAIL ovf_writes got %0d want 16", wc);
      end
      checks++;
      if ({b_ld_err, saw_hold, b_state, b_ld_ready} !== {1'b1, 1'b1, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL ovf_status got err=%b hold=%b st=%0d rdy=%b want 1 1 3 0", b_ld_err, saw_hold, b_state, b_ld_ready);
      end
      b_ld_valid = 1'b0;
      b_cmd_load = 1'b1;
      @(negedge clk);
      b_cmd_load = 1'b0;
      checks++;
      if ({b_state, b_ld_err} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL reload_clears_err got st=%0d err=%b want 1 0", b_state, b_ld_err);
      end
   endtask

   initial begin
      test_reset();
      test_load_b2b();
      test_load_stall();
      test_step();
      test_breakpoint();
      test_load_halt_rst();
      test_addr_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
